// File: rtl/eros_pkg.sv
// eros_pkg: shared types and constants for the safe-CPU wrapper CSR path.
//   - CSR_ARB_* : default sizing of the CSR access arbiter
//   - csr_arb_state_e : arbiter FSM state encoding
//   - obi_req_t / obi_resp_t : OBI data-master request/response bundles
//   - reg_req_t / reg_rsp_t  : single-access register bus bundles
package eros_pkg;

  localparam int          CSR_ARB_NHARTS    = 3;
  // One master per hart plus the external master.
  localparam int          CSR_ARB_NMASTER   = CSR_ARB_NHARTS + 1;
  localparam int          CSR_ARB_TIMEOUT   = 64;
  localparam logic [31:0] CSR_ARB_ERR_RDATA = 32'hBADC_AB1E;

  typedef enum logic [1:0] {
    CSR_ARB_IDLE = 2'd0,
    CSR_ARB_BUSY = 2'd1,
    CSR_ARB_RESP = 2'd2
  } csr_arb_state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

// File: rtl/csr_rr_pick.sv
// csr_rr_pick: combinational round-robin picker.
//   req        : request vector, one bit per master
//   ptr        : index of the last winner; scanning starts at ptr+1 and wraps
//   gnt_onehot : one-hot winner (all zero when nothing requests)
//   idx        : winner index (valid when found)
//   found      : at least one request is pending
module csr_rr_pick #(
  parameter int NMASTER = 4,
  parameter int IW      = $clog2(NMASTER)
) (
  input  logic [NMASTER-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NMASTER-1:0] gnt_onehot,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [31:0] cand;

  // The last candidate examined (k == NMASTER) is ptr itself, so the most
  // recent winner has lowest priority.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NMASTER; k++) begin
      cand = 32'(ptr) + 32'(k);
      if (cand >= 32'(NMASTER)) begin
        cand = cand - 32'(NMASTER);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NMASTER; gi++) begin : g_onehot
    assign gnt_onehot[gi] = found && (idx == IW'(gi));
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: shares the single CSR register port among NMASTER OBI
// data masters. Round-robin grant in IDLE, one reg-bus access in BUSY bounded
// by a watchdog, one-cycle rvalid back to the owner in RESP.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   master_req_i   : per-master OBI request (req, we, be, addr, wdata)
//   master_resp_o  : per-master OBI response (gnt, rvalid, rdata)
//   reg_req_o      : CSR access (valid, write, addr, wdata, wstrb)
//   reg_rsp_i      : CSR response (ready, rdata, error)
//   err_valid_o    : one-cycle pulse on a slave error or timeout
//   err_master_o   : owner of the failed access (0 when no pulse)
//   busy_o         : arbiter is not idle
module csr_access_arbiter
  import eros_pkg::*;
#(
  parameter int          NMASTER   = CSR_ARB_NMASTER,
  parameter int          TIMEOUT   = CSR_ARB_TIMEOUT,
  parameter logic [31:0] ERR_RDATA = CSR_ARB_ERR_RDATA
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  obi_req_t                   master_req_i  [NMASTER],
  output obi_resp_t                  master_resp_o [NMASTER],
  output reg_req_t                   reg_req_o,
  input  reg_rsp_t                   reg_rsp_i,
  output logic                       err_valid_o,
  output logic [$clog2(NMASTER)-1:0] err_master_o,
  output logic                       busy_o
);

  localparam int IW = $clog2(NMASTER);
  localparam int CW = $clog2(TIMEOUT);

  csr_arb_state_e state_reg;
  logic [IW-1:0]  ptr_reg;
  logic [IW-1:0]  owner_reg;
  logic           we_reg;
  logic [3:0]     be_reg;
  logic [31:0]    addr_reg;
  logic [31:0]    wdata_reg;
  logic [31:0]    rdata_reg;
  logic           err_reg;
  logic [CW-1:0]  cnt_reg;

  logic [NMASTER-1:0] req_vec;
  logic [NMASTER-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic               grant_en;
  logic               in_resp;

  for (genvar gi = 0; gi < NMASTER; gi++) begin : g_req
    assign req_vec[gi] = master_req_i[gi].req;
  end

  csr_rr_pick #(
    .NMASTER (NMASTER),
    .IW      (IW)
  ) u_pick (
    .req        (req_vec),
    .ptr        (ptr_reg),
    .gnt_onehot (pick_onehot),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  // A grant seen during reset would not be honoured, so it is suppressed.
  assign grant_en = (state_reg == CSR_ARB_IDLE) && !rst_i;
  assign in_resp  = (state_reg == CSR_ARB_RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= CSR_ARB_IDLE;
      ptr_reg   <= IW'(NMASTER - 1);
      owner_reg <= '0;
      we_reg    <= 1'b0;
      be_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        CSR_ARB_IDLE: begin
          if (pick_found) begin
            owner_reg <= pick_idx;
            ptr_reg   <= pick_idx;
            we_reg    <= master_req_i[pick_idx].we;
            be_reg    <= master_req_i[pick_idx].be;
            addr_reg  <= master_req_i[pick_idx].addr;
            wdata_reg <= master_req_i[pick_idx].wdata;
            cnt_reg   <= '0;
            state_reg <= CSR_ARB_BUSY;
          end
        end
        CSR_ARB_BUSY: begin
          cnt_reg <= cnt_reg + CW'(1);
          // ready is checked first so a response on the last allowed cycle
          // still delivers real data.
          if (reg_rsp_i.ready) begin
            rdata_reg <= reg_rsp_i.rdata;
            err_reg   <= reg_rsp_i.error;
            state_reg <= CSR_ARB_RESP;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            rdata_reg <= ERR_RDATA;
            err_reg   <= 1'b1;
            state_reg <= CSR_ARB_RESP;
          end
        end
        CSR_ARB_RESP: begin
          state_reg <= CSR_ARB_IDLE;
        end
        default: begin
          state_reg <= CSR_ARB_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    reg_req_o = '0;
    if (state_reg == CSR_ARB_BUSY) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.write = we_reg;
      reg_req_o.addr  = addr_reg;
      reg_req_o.wdata = wdata_reg;
      reg_req_o.wstrb = be_reg;
    end
  end

  for (genvar gi = 0; gi < NMASTER; gi++) begin : g_resp
    logic own_resp;
    assign own_resp                  = in_resp && (owner_reg == IW'(gi));
    assign master_resp_o[gi].gnt     = grant_en && pick_onehot[gi];
    assign master_resp_o[gi].rvalid  = own_resp;
    assign master_resp_o[gi].rdata   = own_resp ? rdata_reg : '0;
  end

  assign err_valid_o  = in_resp && err_reg;
  assign err_master_o = err_valid_o ? owner_reg : '0;
  assign busy_o       = (state_reg != CSR_ARB_IDLE);

endmodule
